pu_obuf_rd_arbiter: RTL and testbench
=====================================

// Module: pu_obuf_rd_arbiter
// PURPOSE
// - Shares the single OBUF read port between NUM_REQ address-walker requesters (PU OBUF load walker, SIMD readback, ...).
// - Round-robin arbitration; a grant locks for BURST_LEN beats, so a multi-FIFO word (NUM_FIFO sub-beats) is never interleaved.
// - Tags each issued read with its requester id and returns the tag RD_LATENCY cycles later for response steering.
// - req_ready never depends combinationally on the same requester's req; walkers that derive mem_req from mem_ready close no loop.
// PARAMETERS
// - NUM_REQ      2                     number of requesters, >=2
// - ADDR_WIDTH   8                     OBUF read address width
// - BURST_LEN    2                     beats per locked grant (= NUM_FIFO of the walker), >=1
// - RD_LATENCY   1                     OBUF read latency in cycles, >=1
// - REQ_ID_W     max(1,$clog2(NUM_REQ)) requester id width
// PORTS
// - clk          in   1                    clock
// - reset        in   1                    synchronous, active-high
// - req          in   NUM_REQ              per-requester read request
// - req_addr     in   NUM_REQ*ADDR_WIDTH   per-requester address; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// - req_ready    out  NUM_REQ              per-requester accept; a beat is req[i]&req_ready[i]
// - buf_rd_ready in   1                    OBUF port / downstream can accept a read this cycle
// - buf_rd_req   out  1                    read strobe to OBUF
// - buf_rd_addr  out  ADDR_WIDTH           read address to OBUF
// - rsp_valid    out  1                    read data valid at OBUF output
// - rsp_id       out  REQ_ID_W             requester that owns the rsp_valid data
// - rsp_last     out  1                    rsp is the final beat of its burst
// - busy         out  1                    burst locked or reads in flight
// BEHAVIOUR
// - State: owner_q (REQ_ID_W), state_q in {IDLE, LOCK}, beat_cnt_q ($clog2(BURST_LEN+1) bits), response pipe of RD_LATENCY stages of {valid, id, last}.
// - Reset: owner_q=0, IDLE, beat_cnt_q=0, pipe cleared. While reset is high, req_ready=0 and buf_rd_req=0. rsp_valid, rsp_last, busy and rsp_id are 0 in the first cycle after reset.
// - req_ready[i] = buf_rd_ready & (owner_q==i) & ~reset. This is the only combinational path to req_ready.
// - Beat: beat = req[owner_q] & req_ready[owner_q].
// - buf_rd_req = beat.
// - buf_rd_addr = req_addr slice of owner_q, always driven, don't-care when buf_rd_req=0.
// - Response: pipe stage 0 loads {beat, owner_q, last_beat}. rsp_* = stage RD_LATENCY-1, so rsp_valid asserts exactly RD_LATENCY cycles after the beat.
// - last_beat = beat & (BURST_LEN==1 | beat_cnt_q==BURST_LEN-1).
// - IDLE with beat:
//   - BURST_LEN>1: go to LOCK, beat_cnt_q=1.
//   - BURST_LEN==1: burst complete, rearbitrate.
// - IDLE without beat:
//   - if req[owner_q]==0 and any other req is high: owner_q <= first requester with req high, searching owner_q+1 .. owner_q+NUM_REQ-1 (mod NUM_REQ).
//   - Switching costs one bubble cycle.
// - LOCK:
//   - owner_q is frozen; each beat increments beat_cnt_q.
//   - If the owner drops req mid-burst, the arbiter waits and no other requester is granted.
//   - The LOCK state never appears when BURST_LEN==1.
// - Burst complete (last_beat):
//   - go to IDLE, beat_cnt_q=0.
//   - owner_q <= first requester with req high in the current cycle, searching owner_q+1 .. owner_q (wrap, self last).
//   - If none is high, owner_q holds.
//   - Back-to-back bursts of different requesters have no bubble.
// - buf_rd_ready=0: no beat, state and counters hold. An owner change in IDLE is still allowed.
// - busy = (state_q==LOCK) | any pipe valid.
// - Reset mid-burst or with reads in flight: lock abandoned, in-flight responses dropped (rsp_valid=0 the next cycle). Requesters must be reset together.
// - The req_addr slice of owner_q must be stable only in a beat cycle; no other address hold rule applies.
// TESTING
// - T1: NUM_REQ=2, BURST_LEN=2, RD_LATENCY=1; req0 only, addr 0x10 then 0x11 -> buf_rd_addr 0x10,0x11 in consecutive cycles; rsp_valid id=0 one cycle after each; rsp_last only on 0x11.
// - T2: req0 and req1 held high -> beat owners 0,0,1,1,0,0 with no bubble; busy high throughout.
// - T3: owner 0 drops req after beat 1 while req1 is high -> req_ready[1] stays 0 until req0 returns and completes beat 2; then owner=1 next cycle.
// - T4: buf_rd_ready=0 for 3 cycles mid-burst -> req_ready=0, buf_rd_req=0, beat_cnt held; the burst resumes at beat 2 with no loss.
// - T5: reset asserted one cycle after beat 1 of a burst -> next cycle owner=0, IDLE, rsp_valid=0, busy=0.
// - T6: IDLE, owner 0, only req1 rises at cycle t -> req_ready[1]=1 at t+1, beat at t+1, rsp_valid id=1 at t+2.

Source files
------------

// File: rtl/pu_obuf_rd_arbiter.sv
// Round-robin arbiter sharing the OBUF read port between address walkers.
// Grants lock for BURST_LEN beats; each read's owner id is returned after RD_LATENCY cycles.
module pu_obuf_rd_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int BURST_LEN  = 2,
   parameter int RD_LATENCY = 1,
   parameter int REQ_ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          buf_rd_ready,
   output logic                          buf_rd_req,
   output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
   output logic                          rsp_valid,
   output logic [REQ_ID_W-1:0]           rsp_id,
   output logic                          rsp_last,
   output logic                          busy
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, LOCK} state_e;

   state_e              state_q, state_d;
   logic [REQ_ID_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

   logic [RD_LATENCY-1:0] pvld_q;
   logic [RD_LATENCY-1:0] plast_q;
   logic [REQ_ID_W-1:0]   pid_q [RD_LATENCY];

   logic                beat;
   logic                last_beat;
   logic                other_found;
   logic [REQ_ID_W-1:0] other_id;

   // req_ready depends only on owner_q, buf_rd_ready and reset, never on req.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = buf_rd_ready & ~reset & (owner_q == REQ_ID_W'(i));
      end
   end

   assign beat        = req[owner_q] & req_ready[owner_q];
   assign last_beat   = beat & ((BURST_LEN == 1) || (beat_cnt_q == CNT_W'(BURST_LEN - 1)));
   assign buf_rd_req  = beat;
   assign buf_rd_addr = req_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];

   // Nearest other requester after owner_q; descending scan so the closest one wins.
   always_comb begin
      int idx;
      idx         = 0;
      other_found = 1'b0;
      other_id    = owner_q;
      for (int k = NUM_REQ - 1; k >= 1; k--) begin
         idx = (int'(owner_q) + k) % NUM_REQ;
         if (req[idx]) begin
            other_found = 1'b1;
            other_id    = REQ_ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      if (last_beat) begin
         // Owner keeps the grant only when nobody else is asking.
         state_d    = IDLE;
         beat_cnt_d = '0;
         if (other_found) owner_d = other_id;
      end else if (beat) begin
         state_d    = LOCK;
         beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end else if ((state_q == IDLE) && !req[owner_q] && other_found) begin
         owner_d = other_id;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pvld_q  <= '0;
         plast_q <= '0;
         for (int s = 0; s < RD_LATENCY; s++) pid_q[s] <= '0;
      end else begin
         pvld_q[0]  <= beat;
         plast_q[0] <= last_beat;
         pid_q[0]   <= owner_q;
         for (int s = 1; s < RD_LATENCY; s++) begin
            pvld_q[s]  <= pvld_q[s-1];
            plast_q[s] <= plast_q[s-1];
            pid_q[s]   <= pid_q[s-1];
         end
      end
   end

   assign rsp_valid = pvld_q[RD_LATENCY-1];
   assign rsp_last  = plast_q[RD_LATENCY-1];
   assign rsp_id    = pid_q[RD_LATENCY-1];
   assign busy      = (state_q == LOCK) | (|pvld_q);

endmodule

// File: tb/tb_pu_obuf_rd_arbiter.sv
// Directed bench for pu_obuf_rd_arbiter (NUM_REQ=2, BURST_LEN=2, RD_LATENCY=1).
module tb_pu_obuf_rd_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [7:0]  a0, a1;
   logic [15:0] req_addr;
   logic [1:0]  req_ready;
   logic        buf_rd_ready;
   logic        buf_rd_req;
   logic [7:0]  buf_rd_addr;
   logic        rsp_valid;
   logic [0:0]  rsp_id;
   logic        rsp_last;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   assign req_addr = {a1, a0};

   always #5 clk = ~clk;

   pu_obuf_rd_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_addr     (req_addr),
      .req_ready    (req_ready),
      .buf_rd_ready (buf_rd_ready),
      .buf_rd_req   (buf_rd_req),
      .buf_rd_addr  (buf_rd_addr),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_last     (rsp_last),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   int own [6] = '{0, 0, 1, 1, 0, 0};

   initial begin
      reset = 1'b1; req = 2'b01; a0 = 8'h00; a1 = 8'h00; buf_rd_ready = 1'b1;
      tick();
      settle();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_buf_rd_req", 32'(buf_rd_req), 32'h0);
      tick();
      reset = 1'b0; req = 2'b00;
      settle();
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("post_rst_rsp_last", 32'(rsp_last), 32'h0);
      chk("post_rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
      chk("post_rst_req_ready", 32'(req_ready), 32'h1);

      // T1: single requester, two-beat burst
      req = 2'b01; a0 = 8'h10;
      settle();
      chk("t1_rd_req0", 32'(buf_rd_req), 32'h1);
      chk("t1_addr0", 32'(buf_rd_addr), 32'h10);
      tick();
      a0 = 8'h11;
      settle();
      chk("t1_rd_req1", 32'(buf_rd_req), 32'h1);
      chk("t1_addr1", 32'(buf_rd_addr), 32'h11);
      chk("t1_rsp_valid0", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_id0", 32'(rsp_id), 32'h0);
      chk("t1_rsp_last0", 32'(rsp_last), 32'h0);
      chk("t1_busy", 32'(busy), 32'h1);
      tick();
      req = 2'b00;
      settle();
      chk("t1_rd_req_idle", 32'(buf_rd_req), 32'h0);
      chk("t1_rsp_valid1", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_last1", 32'(rsp_last), 32'h1);
      chk("t1_rsp_id1", 32'(rsp_id), 32'h0);
      tick();
      settle();
      chk("t1_drain_valid", 32'(rsp_valid), 32'h0);
      chk("t1_drain_busy", 32'(busy), 32'h0);

      // T2: both requesting, bursts alternate without bubbles
      req = 2'b11; a0 = 8'h20; a1 = 8'h30;
      for (int i = 0; i < 6; i++) begin
         settle();
         chk("t2_req_ready", 32'(req_ready), 32'(1 << own[i]));
         chk("t2_rd_req", 32'(buf_rd_req), 32'h1);
         chk("t2_addr", 32'(buf_rd_addr), (own[i] == 1) ? 32'h30 : 32'h20);
         if (i > 0) begin
            chk("t2_busy", 32'(busy), 32'h1);
            chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("t2_rsp_id", 32'(rsp_id), 32'(own[i-1]));
            chk("t2_rsp_last", 32'(rsp_last), 32'((i % 2) == 0));
         end
         tick();
      end
      req = 2'b00;
      settle();
      chk("t2_tail_id", 32'(rsp_id), 32'h0);
      chk("t2_tail_last", 32'(rsp_last), 32'h1);
      chk("t2_tail_busy", 32'(busy), 32'h1);
      tick();
      // owner is 1 now; req0 alone causes a one-cycle switch bubble
      req = 2'b01;
      settle();
      chk("sw_req_ready", 32'(req_ready), 32'h2);
      chk("sw_bubble", 32'(buf_rd_req), 32'h0);
      tick();

      // T3: owner drops req mid-burst, other requester must wait
      settle();
      chk("t3_beat1", 32'(buf_rd_req), 32'h1);
      tick();
      req = 2'b10;
      settle();
      chk("t3_hold_ready_a", 32'(req_ready), 32'h1);
      chk("t3_hold_rd_a", 32'(buf_rd_req), 32'h0);
      tick();
      settle();
      chk("t3_hold_ready_b", 32'(req_ready), 32'h1);
      chk("t3_hold_rd_b", 32'(buf_rd_req), 32'h0);
      chk("t3_hold_busy", 32'(busy), 32'h1);
      tick();
      req = 2'b11;
      settle();
      chk("t3_beat2", 32'(buf_rd_req), 32'h1);
      chk("t3_beat2_ready", 32'(req_ready), 32'h1);
      tick();
      settle();
      chk("t3_handoff_ready", 32'(req_ready), 32'h2);
      chk("t3_handoff_rd", 32'(buf_rd_req), 32'h1);
      chk("t3_last_rsp", 32'(rsp_last), 32'h1);
      chk("t3_last_id", 32'(rsp_id), 32'h0);
      tick();
      settle();
      chk("t3_owner1_beat2", 32'(req_ready), 32'h2);
      tick();
      req = 2'b00;
      tick();
      tick();

      // T4: downstream stall mid-burst
      req = 2'b01; a0 = 8'h40;
      settle();
      chk("t4_beat1", 32'(buf_rd_req), 32'h1);
      chk("t4_ready_owner0", 32'(req_ready), 32'h1);
      tick();
      buf_rd_ready = 1'b0; a0 = 8'h41;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t4_stall_ready", 32'(req_ready), 32'h0);
         chk("t4_stall_rd", 32'(buf_rd_req), 32'h0);
         chk("t4_stall_busy", 32'(busy), 32'h1);
         chk("t4_stall_rsp", 32'(rsp_valid), 32'(i == 0));
         tick();
      end
      buf_rd_ready = 1'b1;
      settle();
      chk("t4_resume_rd", 32'(buf_rd_req), 32'h1);
      chk("t4_resume_addr", 32'(buf_rd_addr), 32'h41);
      tick();
      req = 2'b00;
      settle();
      chk("t4_rsp_last", 32'(rsp_last), 32'h1);
      chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
      tick();

      // T6: owner 0 idle, only req1 rises
      req = 2'b10; a1 = 8'h55;
      settle();
      chk("t6_t_ready", 32'(req_ready), 32'h1);
      chk("t6_t_rd", 32'(buf_rd_req), 32'h0);
      tick();
      settle();
      chk("t6_t1_ready", 32'(req_ready), 32'h2);
      chk("t6_t1_rd", 32'(buf_rd_req), 32'h1);
      chk("t6_t1_addr", 32'(buf_rd_addr), 32'h55);
      tick();
      settle();
      chk("t6_t2_valid", 32'(rsp_valid), 32'h1);
      chk("t6_t2_id", 32'(rsp_id), 32'h1);
      chk("t6_t2_last", 32'(rsp_last), 32'h0);

      // T5: reset one cycle after beat 1 of owner 1's burst
      reset = 1'b1;
      settle();
      chk("t5_rst_ready", 32'(req_ready), 32'h0);
      chk("t5_rst_rd", 32'(buf_rd_req), 32'h0);
      tick();
      reset = 1'b0; req = 2'b00;
      settle();
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_rsp_id", 32'(rsp_id), 32'h0);
      chk("t5_owner0", 32'(req_ready), 32'h1);
      req = 2'b01; a0 = 8'h60;
      settle();
      chk("t5_new_rd", 32'(buf_rd_req), 32'h1);
      tick();
      settle();
      chk("t5_first_not_last", 32'(rsp_last), 32'h0);
      chk("t5_first_valid", 32'(rsp_valid), 32'h1);
      tick();
      req = 2'b00;
      settle();
      chk("t5_second_last", 32'(rsp_last), 32'h1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
